// File: rtl/shift_pipe_2s.sv
// Two-stage 32-bit barrel shifter (SLL/SRA) with valid/ready at both ends.
// Stage 1 resolves shamt[4:3]; stage 2 resolves shamt[2:0]; includes flush and a retired-op counter.
module shift_pipe_2s #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_in_data,
    input  logic [4:0]       i_in_shamt,
    input  logic             i_in_op,
    input  logic [TAG_W-1:0] i_in_tag,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [31:0]      o_out_data,
    output logic [TAG_W-1:0] o_out_tag,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_op_count
);

    logic             r_v1;
    logic [31:0]      r_d1;
    logic [2:0]       r_sh1;
    logic             r_sign1;
    logic             r_op1;
    logic [TAG_W-1:0] r_tag1;

    logic             r_v2;
    logic [31:0]      r_d2;
    logic [TAG_W-1:0] r_tag2;

    logic [CNT_W-1:0] r_cnt;

    logic             w_rdy1;
    logic             w_rdy2;
    logic             w_sign_in;
    logic [31:0]      w_s16;
    logic [31:0]      w_s8;
    logic [31:0]      w_s4;
    logic [31:0]      w_s2;
    logic [31:0]      w_s1;

    assign w_rdy2     = !r_v2 | i_out_ready;
    assign w_rdy1     = !r_v1 | w_rdy2;
    assign o_in_ready = w_rdy1 & !i_flush & i_reset;

    // Fill bit for right shifts; zero for SLL so stage 2 never needs the raw operand.
    assign w_sign_in = i_in_op & i_in_data[31];

    assign w_s16 = !i_in_shamt[4] ? i_in_data :
                   i_in_op        ? {{16{w_sign_in}}, i_in_data[31:16]} :
                                    {i_in_data[15:0], 16'h0000};
    assign w_s8  = !i_in_shamt[3] ? w_s16 :
                   i_in_op        ? {{8{w_sign_in}}, w_s16[31:8]} :
                                    {w_s16[23:0], 8'h00};

    assign w_s4  = !r_sh1[2] ? r_d1 :
                   r_op1     ? {{4{r_sign1}}, r_d1[31:4]} :
                               {r_d1[27:0], 4'h0};
    assign w_s2  = !r_sh1[1] ? w_s4 :
                   r_op1     ? {{2{r_sign1}}, w_s4[31:2]} :
                               {w_s4[29:0], 2'b00};
    assign w_s1  = !r_sh1[0] ? w_s2 :
                   r_op1     ? {r_sign1, w_s2[31:1]} :
                               {w_s2[30:0], 1'b0};

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_v1    <= 1'b0;
            r_d1    <= '0;
            r_sh1   <= '0;
            r_sign1 <= 1'b0;
            r_op1   <= 1'b0;
            r_tag1  <= '0;
        end else begin
            if (i_flush) begin
                r_v1 <= 1'b0;
            end else if (w_rdy1) begin
                r_v1 <= i_in_valid;
            end
            if (w_rdy1) begin
                r_d1    <= w_s8;
                r_sh1   <= i_in_shamt[2:0];
                r_sign1 <= w_sign_in;
                r_op1   <= i_in_op;
                r_tag1  <= i_in_tag;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_v2   <= 1'b0;
            r_d2   <= '0;
            r_tag2 <= '0;
        end else begin
            if (i_flush) begin
                r_v2 <= 1'b0;
            end else if (w_rdy2) begin
                r_v2 <= r_v1;
            end
            if (w_rdy2) begin
                r_d2   <= w_s1;
                r_tag2 <= r_tag1;
            end
        end
    end

    // A transfer in the flush cycle still retires, so the counter ignores flush.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (r_v2 && i_out_ready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_out_valid = r_v2;
    assign o_out_data  = r_d2;
    assign o_out_tag   = r_tag2;
    assign o_busy      = r_v1 | r_v2;
    assign o_op_count  = r_cnt;

endmodule
